pipe_flow_ctrl: RTL and testbench

//  Central stall/flush/redirect sequencer for the 5-stage pipeline registers (F/D, D/E, E/M, M/W).

---
 rtl/pipe_flow_ctrl.sv | 68 ++++++
 tb/tb_pipe_flow_ctrl.sv | 88 ++++++++
 2 files changed

// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: stall/flush/redirect sequencer for the F/D, D/E, E/M, M/W pipeline registers
//   in : clk, reset (async, active-high), hz_stall, mdu_start, mdu_div, mdu_use_D, int_pend, exc_M, eret_M
//   out: stall_F, stall_D, flush_D, flush_E, flush_M, flush_W, pc_sel[1:0], int_req, mdu_busy
module pipe_flow_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int HOLD_CYC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hz_stall,
  input  logic       mdu_start,
  input  logic       mdu_div,
  input  logic       mdu_use_D,
  input  logic       int_pend,
  input  logic       exc_M,
  input  logic       eret_M,
  output logic       stall_F,
  output logic       stall_D,
  output logic       flush_D,
  output logic       flush_E,
  output logic       flush_M,
  output logic       flush_W,
  output logic [1:0] pc_sel,
  output logic       int_req,
  output logic       mdu_busy
);
  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  typedef enum logic {RUN, HOLD} state_t;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [HW-1:0] r_hold, w_hold;
  logic          w_irq, w_eret, w_redir, w_st;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_hold  <= w_hold;
    end
  end
  always_comb begin
    w_irq    = (r_state == RUN) & (int_pend | exc_M);
    w_eret   = (r_state == RUN) & eret_M & ~(int_pend | exc_M);
    w_redir  = w_irq | w_eret;
    mdu_busy = (r_cnt != '0);
    w_st     = hz_stall | (mdu_use_D & (mdu_busy | mdu_start));
    // a redirect flushes everything, so it wins over any stall request
    stall_F  = w_st & ~w_redir;
    stall_D  = w_st & ~w_redir;
    flush_D  = w_redir;
    flush_E  = w_redir | w_st;
    flush_M  = w_redir;
    flush_W  = w_redir;
    pc_sel   = w_irq ? 2'b01 : w_eret ? 2'b10 : 2'b00;
    int_req  = w_irq;
    // the mult/div in E is being flushed on a redirect, so it must not start the counter
    w_cnt    = (mdu_start & ~w_redir) ? (mdu_div ? CW'(DIV_CYC) : CW'(MULT_CYC)) :
               mdu_busy ? r_cnt - CW'(1) : r_cnt;
    w_hold   = w_redir ? HW'(HOLD_CYC) : (r_hold != '0) ? r_hold - HW'(1) : r_hold;
    w_next   = w_redir ? HOLD : (r_state == HOLD && r_hold == HW'(1)) ? RUN : r_state;
  end
endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb_pipe_flow_ctrl: directed scoreboard bench for pipe_flow_ctrl
module tb_pipe_flow_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic hz_stall = 0, mdu_start = 0, mdu_div = 0, mdu_use_D = 0, int_pend = 0, exc_M = 0, eret_M = 0;
  logic stall_F, stall_D, flush_D, flush_E, flush_M, flush_W, int_req, mdu_busy;
  logic [1:0] pc_sel;
  int total = 0, bad = 0;
  string q_name[$];
  logic [9:0] q_exp[$];
  pipe_flow_ctrl dut (
    .clk(clk), .reset(reset), .hz_stall(hz_stall), .mdu_start(mdu_start), .mdu_div(mdu_div),
    .mdu_use_D(mdu_use_D), .int_pend(int_pend), .exc_M(exc_M), .eret_M(eret_M),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
    .flush_M(flush_M), .flush_W(flush_W), .pc_sel(pc_sel), .int_req(int_req), .mdu_busy(mdu_busy)
  );
  always #5 clk = ~clk;
  // expected word: {stall_F, stall_D, flush_D, flush_E, flush_M, flush_W, pc_sel, int_req, mdu_busy}
  localparam logic [9:0] IDLE = 10'b00_0000_00_00;
  localparam logic [9:0] BUSY = 10'b00_0000_00_01;
  localparam logic [9:0] STL  = 10'b11_0100_00_00;
  localparam logic [9:0] STLB = 10'b11_0100_00_01;
  localparam logic [9:0] IRQ  = 10'b00_1111_01_10;
  localparam logic [9:0] IRQB = 10'b00_1111_01_11;
  localparam logic [9:0] ERET = 10'b00_1111_10_00;
  // in = {reset, hz_stall, mdu_start, mdu_div, mdu_use_D, int_pend, exc_M, eret_M}
  task automatic cyc(input string n, input logic [7:0] in, input logic [9:0] e);
    @(posedge clk);
    #1;
    {reset, hz_stall, mdu_start, mdu_div, mdu_use_D, int_pend, exc_M, eret_M} = in;
    q_name.push_back(n);
    q_exp.push_back(e);
  endtask
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      automatic string n = q_name.pop_front();
      automatic logic [9:0] e = q_exp.pop_front();
      automatic logic [9:0] a = {stall_F, stall_D, flush_D, flush_E, flush_M, flush_W, pc_sel, int_req, mdu_busy};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s got=%b exp=%b", n, a, e);
      end
    end
  end
  initial begin
    for (int i = 0; i < 3; i++) cyc("reset_hold", 8'b1010_0000, IDLE);
    cyc("reset_release", 8'b0000_0000, IDLE);
    cyc("mult_start", 8'b0010_1000, STL);
    for (int i = 1; i <= 5; i++) cyc($sformatf("mult_stall%0d", i), 8'b0000_1000, STLB);
    cyc("mult_release", 8'b0000_1000, IDLE);
    cyc("div_start", 8'b0011_0000, IDLE);
    cyc("div_c1", 8'b0000_0000, BUSY);
    cyc("div_c2", 8'b0000_0000, BUSY);
    cyc("div_int", 8'b0000_0100, IRQB);
    for (int i = 4; i <= 10; i++) cyc($sformatf("div_c%0d", i), 8'b0000_0000, BUSY);
    cyc("div_done", 8'b0000_0000, IDLE);
    cyc("int_eret", 8'b0000_0101, IRQ);
    cyc("hold_ignore", 8'b0000_0101, IDLE);
    cyc("after_hold", 8'b0000_0000, IDLE);
    cyc("eret_hz", 8'b0100_0001, ERET);
    cyc("hold_stall", 8'b0100_0000, STL);
    cyc("eret_idle", 8'b0000_0000, IDLE);
    cyc("exc_start", 8'b0011_1010, IRQ);
    cyc("exc_nobusy", 8'b0000_1000, IDLE);
    cyc("exc_idle", 8'b0000_0000, IDLE);
    cyc("div2_start", 8'b0011_0000, IDLE);
    cyc("div2_c1", 8'b0000_0000, BUSY);
    cyc("div2_c2", 8'b0000_0000, BUSY);
    @(posedge clk);
    #1;
    mdu_start = 0;
    mdu_div = 0;
    #1 reset = 1'b1;
    q_name.push_back("async_rst");
    q_exp.push_back(IDLE);
    @(negedge clk);
    #1 reset = 1'b0;
    cyc("post_rst", 8'b0000_1000, IDLE);
    cyc("post_rst2", 8'b0000_0000, IDLE);
    for (int i = 0; i < 20 && q_exp.size() > 0; i++) @(posedge clk);
    if (q_exp.size() > 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", q_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
